// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - shared address offsets and address-width helper for spi_regbank
package spi_regbank_pkg;

  // Flag and mask registers sit directly after the status range.
  localparam int FLAG_OFS = 0;
  localparam int MASK_OFS = 1;

  function automatic int addr_width(input int num_cfg, input int num_status);
    return $clog2(num_cfg + num_status + 2);
  endfunction

endpackage

// File: rtl/spi_reg.sv
// rtl/spi_reg.sv - SPI slave serial core: {rw, addr, data} frames, MSB first, all four CPOL/CPHA modes
module spi_reg #(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [1:0]        mode,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [REG_W-1:0]  status,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [REG_W-1:0]  rd_data,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [REG_W-1:0]  wr_data
);

  localparam int HDR   = 1 + ADDR_W;
  localparam int FRAME = HDR + REG_W;
  localparam int CNT_W = $clog2(FRAME + 1);

  logic [2:0]         cs_sync;
  logic [2:0]         sclk_sync;
  logic [1:0]         mosi_sync;
  logic               armed;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME-2:0]   rx_sr;
  logic [REG_W-1:0]   tx_sr;
  logic               in_frame;
  logic               frame_start;
  logic               sclk_rise;
  logic               sclk_fall;
  logic               sample_on_rise;
  logic               sample_edge;
  logic               shift_edge;

  // A frame only counts once chip-select has been seen high since reset,
  // so a reset in the middle of a transfer cannot resume it.
  assign in_frame       = armed & ~cs_sync[1];
  assign frame_start    = armed & cs_sync[2] & ~cs_sync[1];
  assign sclk_rise      = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall      = ~sclk_sync[1] & sclk_sync[2];
  assign sample_on_rise = (mode[1] == mode[0]);
  assign sample_edge    = in_frame & (sample_on_rise ? sclk_rise : sclk_fall);
  assign shift_edge     = in_frame & (sample_on_rise ? sclk_fall : sclk_rise);

  assign spi_miso = tx_sr[REG_W-1];
  assign rd_addr  = rx_sr[ADDR_W-1:0];
  assign wr_addr  = rx_sr[REG_W +: ADDR_W];
  assign wr_data  = rx_sr[REG_W-1:0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      armed     <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      wr_valid  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      armed     <= armed | cs_sync[1];
      wr_valid  <= 1'b0;
      if (!in_frame) begin
        bit_cnt <= '0;
      end
      // First shift edge of a CPHA=1 frame only presents the already-loaded MSB.
      if (frame_start) begin
        tx_sr <= status;
      end else if (shift_edge) begin
        if (bit_cnt == CNT_W'(HDR)) begin
          tx_sr <= rd_data;
        end else if (bit_cnt != '0) begin
          tx_sr <= {tx_sr[REG_W-2:0], 1'b0};
        end
      end
      if (sample_edge && bit_cnt < CNT_W'(FRAME)) begin
        rx_sr    <= {rx_sr[FRAME-3:0], mosi_sync[1]};
        bit_cnt  <= bit_cnt + 1'b1;
        wr_valid <= (bit_cnt == CNT_W'(FRAME - 1)) & rx_sr[FRAME-2];
      end
    end
  end

endmodule

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI-accessible config/status register bank with change flags and irq
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 4,
  parameter int REG_WIDTH  = 8,
  parameter logic [NUM_CFG*REG_WIDTH-1:0] CFG_RST = '0
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [1:0]                      mode,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  output logic                            spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic [NUM_CFG-1:0]              cfg_wr_pulse,
  output logic                            irq
);

  localparam int ADDR_W = addr_width(NUM_CFG, NUM_STATUS);
  localparam int A_FLAG = NUM_CFG + NUM_STATUS + FLAG_OFS;
  localparam int A_MASK = NUM_CFG + NUM_STATUS + MASK_OFS;

  logic [ADDR_W-1:0]               rd_addr;
  logic [ADDR_W-1:0]               wr_addr;
  logic [REG_WIDTH-1:0]            rd_data;
  logic [REG_WIDTH-1:0]            wr_data;
  logic                            wr_valid;
  logic                            wr_ok;
  logic [31:0]                     ra;
  logic [31:0]                     wa;
  logic [NUM_CFG*REG_WIDTH-1:0]    cfg_q;
  logic [NUM_STATUS*REG_WIDTH-1:0] status_q;
  logic [NUM_STATUS-1:0]           flag_q;
  logic [NUM_STATUS-1:0]           mask_q;
  logic [NUM_STATUS-1:0]           flag_set;
  logic [NUM_STATUS-1:0]           flag_clr;
  logic                            prime;

  spi_reg #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_WIDTH)
  ) u_spi_reg (
    .clk      (clk),
    .rstb     (rstb),
    .mode     (mode),
    .spi_cs_n (spi_cs_n),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .status   ('0),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  assign ra          = 32'(rd_addr);
  assign wa          = 32'(wr_addr);
  assign wr_ok       = wr_valid & ena;
  assign config_regs = cfg_q;

  // Set beats clear: flag_set is OR-ed in after the W1C mask is applied.
  always_comb begin
    flag_set = '0;
    flag_clr = '0;
    for (int j = 0; j < NUM_STATUS; j++) begin
      flag_set[j] = ena & prime &
                    (status_regs[j*REG_WIDTH +: REG_WIDTH] != status_q[j*REG_WIDTH +: REG_WIDTH]);
    end
    if (wr_ok && wa == 32'(A_FLAG)) begin
      flag_clr = wr_data[NUM_STATUS-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    if (ra < 32'(NUM_CFG)) begin
      rd_data = cfg_q[ra*REG_WIDTH +: REG_WIDTH];
    end else if (ra < 32'(NUM_CFG + NUM_STATUS)) begin
      rd_data = status_q[(ra - 32'(NUM_CFG))*REG_WIDTH +: REG_WIDTH];
    end else if (ra == 32'(A_FLAG)) begin
      rd_data = REG_WIDTH'(flag_q);
    end else if (ra == 32'(A_MASK)) begin
      rd_data = REG_WIDTH'(mask_q);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cfg_q        <= CFG_RST;
      cfg_wr_pulse <= '0;
      status_q     <= '0;
      flag_q       <= '0;
      mask_q       <= '0;
      irq          <= 1'b0;
      prime        <= 1'b0;
    end else begin
      status_q <= status_regs;
      prime    <= 1'b1;
      flag_q   <= (flag_q & ~flag_clr) | flag_set;
      irq      <= |(flag_q & mask_q);
      if (wr_ok && wa == 32'(A_MASK)) begin
        mask_q <= wr_data[NUM_STATUS-1:0];
      end
      for (int k = 0; k < NUM_CFG; k++) begin
        cfg_wr_pulse[k] <= wr_ok && (wa == 32'(k));
        if (wr_ok && (wa == 32'(k))) begin
          cfg_q[k*REG_WIDTH +: REG_WIDTH] <= wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regbank.sv
// tb/tb_spi_regbank.sv - scoreboard bench for spi_regbank driving an SPI master model
module tb_spi_regbank;

  localparam int NC     = 8;
  localparam int NS     = 4;
  localparam int RW     = 8;
  localparam int AW     = 4;
  localparam int HDR    = 1 + AW;
  localparam int FRAME  = HDR + RW;
  localparam int A_FLAG = NC + NS;
  localparam int A_MASK = NC + NS + 1;
  localparam int HALF   = 8;
  localparam logic [NC*RW-1:0] CFG_RST_P = 64'h0000_0000_00A5_0000;

  logic            clk = 1'b0;
  logic            rstb;
  logic            ena;
  logic [1:0]      mode;
  logic            spi_cs_n;
  logic            spi_clk;
  logic            spi_mosi;
  logic            spi_miso;
  logic [NC*RW-1:0] config_regs;
  logic [NS*RW-1:0] status_regs;
  logic [NC-1:0]   cfg_wr_pulse;
  logic            irq;

  always #5 clk = ~clk;

  spi_regbank #(
    .NUM_CFG    (NC),
    .NUM_STATUS (NS),
    .REG_WIDTH  (RW),
    .CFG_RST    (CFG_RST_P)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .ena          (ena),
    .mode         (mode),
    .spi_cs_n     (spi_cs_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .config_regs  (config_regs),
    .status_regs  (status_regs),
    .cfg_wr_pulse (cfg_wr_pulse),
    .irq          (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [RW-1:0] m_cfg [NC];
  logic [RW-1:0] m_stat [NS];
  logic [NS-1:0] m_flag;
  logic [NS-1:0] m_mask;
  bit            m_ena;

  typedef struct {
    logic [NC-1:0]    pulse;
    logic [NC*RW-1:0] cfg;
  } wr_exp_t;

  wr_exp_t       exp_wr_q [$];
  logic [RW-1:0] exp_rd_q [$];
  logic [RW-1:0] obs_rd_q [$];
  wr_exp_t       e_wr;

  event last_sample_ev;
  int   rst_at_bit = -1;
  int   lat_k = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NC*RW-1:0] pack_cfg();
    logic [NC*RW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*RW +: RW] = m_cfg[k];
    return v;
  endfunction

  function automatic logic [RW-1:0] model_read(input int a);
    if (a < NC) return m_cfg[a];
    if (a < NC + NS) return m_stat[a - NC];
    if (a == A_FLAG) return RW'(m_flag);
    if (a == A_MASK) return RW'(m_mask);
    return '0;
  endfunction

  task automatic model_reset();
    logic [NC*RW-1:0] r;
    r = CFG_RST_P;
    for (int k = 0; k < NC; k++) m_cfg[k] = r[k*RW +: RW];
    m_flag = '0;
    m_mask = '0;
  endtask

  task automatic half_bit();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_xfer(input bit wr, input int addr, input int data, output logic [RW-1:0] rdata);
    logic [FRAME-1:0] fr;
    logic cpol;
    logic cpha;
    cpol  = mode[1];
    cpha  = mode[0];
    fr    = {wr, AW'(addr), RW'(data)};
    rdata = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    half_bit();
    for (int i = 0; i < FRAME; i++) begin
      if (i == rst_at_bit) begin
        rstb = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
      end
      if (!cpha) begin
        spi_mosi = fr[FRAME-1-i];
        half_bit();
        spi_clk = ~cpol;
        if (i >= HDR) rdata = {rdata[RW-2:0], spi_miso};
        if (i == FRAME - 1) -> last_sample_ev;
        half_bit();
        spi_clk = cpol;
      end else begin
        spi_clk  = ~cpol;
        spi_mosi = fr[FRAME-1-i];
        half_bit();
        spi_clk = cpol;
        if (i >= HDR) rdata = {rdata[RW-2:0], spi_miso};
        if (i == FRAME - 1) -> last_sample_ev;
        half_bit();
      end
    end
    half_bit();
    spi_cs_n = 1'b1;
    half_bit();
  endtask

  task automatic do_write(input int addr, input int data);
    logic [RW-1:0] d;
    logic [RW-1:0] dummy;
    d = RW'(data);
    if (m_ena) begin
      if (addr < NC) begin
        m_cfg[addr] = d;
        e_wr.pulse = NC'(1) << addr;
        e_wr.cfg   = pack_cfg();
        exp_wr_q.push_back(e_wr);
      end else if (addr == A_FLAG) begin
        m_flag = m_flag & ~d[NS-1:0];
      end else if (addr == A_MASK) begin
        m_mask = d[NS-1:0];
      end
    end
    spi_xfer(1'b1, addr, data, dummy);
    check("irq_after_write", irq, |(m_flag & m_mask));
  endtask

  task automatic do_read(input int addr);
    logic [RW-1:0] r;
    exp_rd_q.push_back(model_read(addr));
    spi_xfer(1'b0, addr, int'($urandom), r);
    obs_rd_q.push_back(r);
  endtask

  task automatic set_status(input int j, input logic [RW-1:0] v);
    @(negedge clk);
    if (m_ena && v != m_stat[j]) m_flag[j] = 1'b1;
    m_stat[j] = v;
    status_regs[j*RW +: RW] = v;
    repeat (3) @(negedge clk);
    check("irq_after_status", irq, |(m_flag & m_mask));
  endtask

  task automatic set_ena(input bit b);
    @(negedge clk);
    ena   = b;
    m_ena = b;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    mode    = m;
    spi_clk = m[1];
    repeat (4) @(negedge clk);
  endtask

  // W1C of flag bit 0 with a status-0 change landing d clocks after the last sample edge
  task automatic race_w1c(input int d);
    fork
      do_write(A_FLAG, 8'h01);
      begin
        logic [RW-1:0] nv;
        @(last_sample_ev);
        repeat (d) @(posedge clk);
        @(negedge clk);
        nv = m_stat[0] ^ 8'hFF;
        m_stat[0] = nv;
        status_regs[0 +: RW] = nv;
        if (d + 1 >= lat_k) m_flag[0] = 1'b1;
      end
    join
    do_read(A_FLAG);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstb === 1'b1 && cfg_wr_pulse !== '0) begin
      if (exp_wr_q.size() == 0) begin
        n_checks <= n_checks + 1;
        n_fail   <= n_fail + 1;
        $display("FAIL unexpected_wr_pulse: got %h expected none, config %h", cfg_wr_pulse, config_regs);
      end else begin
        wr_exp_t e;
        e = exp_wr_q.pop_front();
        check("wr_pulse", cfg_wr_pulse, e.pulse);
        check("wr_config", config_regs, e.cfg);
      end
    end
    if (obs_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
      check("rd_data", obs_rd_q.pop_front(), exp_rd_q.pop_front());
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] dummy;
    rstb        = 1'b0;
    ena         = 1'b1;
    m_ena       = 1'b1;
    mode        = 2'b00;
    spi_cs_n    = 1'b1;
    spi_clk     = 1'b0;
    spi_mosi    = 1'b0;
    m_stat[0]   = 8'h5A;
    m_stat[1]   = 8'h00;
    m_stat[2]   = 8'h33;
    m_stat[3]   = 8'h00;
    for (int j = 0; j < NS; j++) status_regs[j*RW +: RW] = m_stat[j];
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_config", config_regs, CFG_RST_P);
    check("rst_irq", irq, 1'b0);
    check("rst_pulse", cfg_wr_pulse, '0);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    check("prime_irq", irq, 1'b0);
    do_read(A_FLAG);
    do_read(2);
    do_read(NC + 2);

    do_write(5, 8'h3C);
    do_read(5);

    // Measure commit latency of the serial core relative to its last sample edge
    fork
      do_write(3, 8'h77);
      begin
        @(last_sample_ev);
        lat_k = 0;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk);
          #1;
          lat_k++;
          if (cfg_wr_pulse != '0) break;
        end
      end
    join
    n_checks++;
    if (lat_k < 3 || lat_k >= 20) begin
      n_fail++;
      $display("FAIL write_latency: got %0d expected 3..19", lat_k);
    end

    do_write(A_MASK, 8'hF2);
    do_read(A_MASK);
    set_status(1, 8'h11);
    check("irq_flag1", irq, 1'b1);
    do_read(A_FLAG);
    do_write(A_FLAG, 8'h02);
    check("irq_cleared", irq, 1'b0);

    do_write(A_MASK, 8'h01);
    race_w1c(lat_k - 3);
    check("race_early_irq", irq, 1'b0);
    race_w1c(lat_k - 1);
    repeat (3) @(negedge clk);
    check("race_same_irq", irq, 1'b1);

    do_read(A_MASK + 1);
    do_read(15);
    do_write(NC + 1, 8'hFF);
    check("status_write_cfg", config_regs, pack_cfg());

    do_write(A_FLAG, 8'hFF);
    set_ena(1'b0);
    set_status(2, 8'h44);
    set_ena(1'b1);
    repeat (3) @(negedge clk);
    do_read(A_FLAG);
    set_ena(1'b0);
    do_write(1, 8'h99);
    do_write(A_MASK, 8'h0F);
    set_ena(1'b1);
    check("ena0_cfg", config_regs, pack_cfg());
    do_read(A_MASK);

    rst_at_bit = 7;
    spi_xfer(1'b1, 4, 8'hEE, dummy);
    rst_at_bit = -1;
    repeat (4) @(negedge clk);
    check("abort_cfg", config_regs, CFG_RST_P);
    check("abort_irq", irq, 1'b0);
    do_read(4);

    for (int md = 0; md < 4; md++) begin
      set_mode(2'(md));
      for (int n = 0; n < 15; n++) begin
        int op;
        op = int'($urandom_range(0, 9));
        if (op <= 4) begin
          do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end else if (op <= 7) begin
          do_read(int'($urandom_range(0, 15)));
        end else if (op == 8) begin
          set_status(int'($urandom_range(0, NS - 1)), RW'($urandom_range(0, 255)));
        end else begin
          set_ena(~m_ena);
        end
      end
      set_ena(1'b1);
      check("mode_cfg", config_regs, pack_cfg());
    end

    repeat (10) @(negedge clk);
    check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 SHALL have parameter NUM_CFG, default 8: number of read/write config registers, 1..32.
REQ-002 SHALL have parameter NUM_STATUS, default 4: number of read-only status registers, 1..REG_WIDTH, independent of NUM_CFG.
REQ-003 SHALL have parameter REG_WIDTH, default 8: register width in bits.
REQ-004 SHALL have parameter CFG_RST, default all-zero, NUM_CFG*REG_WIDTH bits: per-register reset values; register k is bits [k*REG_WIDTH +: REG_WIDTH].
REQ-005 SHALL have port clk, input, 1: system clock.
REQ-006 SHALL have port rstb, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port ena, input, 1: block enable.
REQ-008 SHALL have port mode, input, 2: SPI CPOL/CPHA, passed to the serial core.
REQ-009 SHALL have ports spi_cs_n, spi_clk, spi_mosi (input, 1 each) and spi_miso (output, 1).
REQ-010 SHALL have port config_regs, output, NUM_CFG*REG_WIDTH: packed config registers; register k at [k*REG_WIDTH +: REG_WIDTH].
REQ-011 SHALL have port status_regs, input, NUM_STATUS*REG_WIDTH: packed status registers, synchronous to clk, same packing.
REQ-012 SHALL have port cfg_wr_pulse, output, NUM_CFG: one-cycle strobe per config register on SPI write.
REQ-013 SHALL have port irq, output, 1: registered interrupt request.

Function
REQ-014 Address map SHALL be: 0..NUM_CFG-1 config; NUM_CFG..NUM_CFG+NUM_STATUS-1 status; A_FLAG=NUM_CFG+NUM_STATUS; A_MASK=A_FLAG+1; ADDR_W=$clog2(NUM_CFG+NUM_STATUS+2).
REQ-015 Reads SHALL return: config value; status value; flags (zero-extended); mask (zero-extended); 0 for any address above A_MASK.
REQ-016 On a serial-core write-valid with ena=1, the addressed config register SHALL update on the next clk edge, and cfg_wr_pulse[k] SHALL be high for exactly that one cycle.
REQ-017 Writes to status or out-of-range addresses SHALL be ignored with no pulse; writes with ena=0 SHALL be ignored entirely.
REQ-018 Every cycle the block SHALL register status_regs into status_q, independent of ena.
REQ-019 With ena=1, flag[j] SHALL set in the cycle after status register j differs from status_q[j].
REQ-020 A write to A_FLAG SHALL clear each flag bit written as 1 (W1C); a simultaneous set event on the same bit SHALL win.
REQ-021 A write to A_MASK SHALL load mask[NUM_STATUS-1:0]; upper bits SHALL be ignored.
REQ-022 irq SHALL equal the registered value of |(flag & mask), one cycle after the flag/mask update.
REQ-023 With ena=0, flags, mask and config SHALL hold; status_q SHALL keep tracking, so re-enabling raises no spurious flags.

Reset
REQ-024 On rstb low, config SHALL load CFG_RST; flag, mask, cfg_wr_pulse and irq SHALL be 0; status_q SHALL be 0.
REQ-025 The first post-reset cycle SHALL set no flags: a one-cycle prime bit SHALL suppress change detection.
REQ-026 Reset mid-SPI-transaction SHALL abort it; no write SHALL commit.

Structure
REQ-027 A shared package SHALL hold the flag/mask address offsets (0, 1 past the status range) and the address-width function.
REQ-028 The existing spi_reg serial core SHALL be instantiated unchanged as the sole sub-module (ADDR_W, REG_W passed through, status tied 0).

Verification
REQ-029 Reset with CFG_RST byte 2 = 0xA5 -> config_regs[23:16]=0xA5, others 0, irq=0.
REQ-030 SPI write 0x3C to addr 5 -> config reg 5 = 0x3C, cfg_wr_pulse=0x20 for one clk, others unchanged.
REQ-031 Mask=0x02, status reg 1 changes 0x00->0x11 -> flag=0x02, irq=1 next cycle; W1C write 0x02 to A_FLAG -> irq=0.
REQ-032 Status reg 0 changes in the same cycle as a W1C of bit 0 -> flag bit 0 stays 1.
REQ-033 Read addr A_MASK+1 -> 0x00; write 0xFF to a status address -> no pulse, config unchanged.
REQ-034 ena=0, status changes, ena=1 -> flag stays 0; SPI write during ena=0 -> config unchanged.
